led_bounce_ctrl: RTL and testbench
==================================

# led_bounce_ctrl

Sequencer for the 8-LED shifter on the 50 MHz board clock. It divides CLOCK_50 into a selectable step tick and runs a state machine that bounces a single lit LED left→right→left, with an optional dwell at each end. It also supports rotate-right, rotate-left and hold modes, and run/stop control. It drives LEDR directly and replaces free-running counter-bit clocking with single-clock-domain, tick-enabled logic.

## Interface
- BASE_DIV, 50_000_000, CLOCK_50 cycles per step at speed 0 (1 Hz); must be ≥ 8 and a multiple of 8.
- PAUSE_TICKS, 1, extra ticks the end LED is held before reversing in bounce mode; 0 = no dwell.
- CLOCK_50  in  1  system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = stepping enabled, 0 = stop and hold pattern.
- mode  in  2  00 bounce, 01 rotate right, 10 rotate left, 11 hold.
- speed  in  2  step period = BASE_DIV >> speed cycles (1/2/4/8 Hz at default).
- LEDR  out  8  LED pattern, one-hot; LEDR[7] leftmost.
- dir  out  1  0 = moving right (toward bit 0), 1 = moving left.
- tick  out  1  registered one-cycle step strobe.

## Operation
- Reset values: LEDR = 8'h80, dir = 0, tick = 0, state IDLE, prescaler = 0, dwell count = 0.
- Prescaler:
  - limit = (BASE_DIV >> speed) − 1.
  - While run = 1: if cnt ≥ limit then cnt ← 0 and tick ← 1; else cnt ← cnt + 1 and tick ← 0.
  - While run = 0: cnt ← 0 and tick ← 0.
  - Width is ceil(log2(BASE_DIV)) bits.
- FSM states IDLE, MOVE, DWELL:
  - IDLE: LEDR and dir held. run = 1 → MOVE on the next edge.
  - MOVE (any state with run = 0 → IDLE on the next edge; LEDR and dir held, dwell count cleared). On tick:
    - Bounce, interior position: shift toward dir. dir = 0 gives {1'b0, LEDR[7:1]}; dir = 1 gives {LEDR[6:0], 1'b0}.
    - Bounce, at the far end (dir = 0 & LEDR = 8'h01, or dir = 1 & LEDR = 8'h80):
      - PAUSE_TICKS = 0: toggle dir and shift one step the new way on the same tick (01 → 02, 80 → 40).
      - PAUSE_TICKS > 0: toggle dir, hold LEDR, dwell count ← 0, go to DWELL.
    - Rotate right: LEDR ← {LEDR[0], LEDR[7:1]}, dir ← 0.
    - Rotate left: LEDR ← {LEDR[6:0], LEDR[7]}, dir ← 1.
    - Hold: no change.
  - DWELL: on each tick, dwell count + 1. On the tick where the count reaches PAUSE_TICKS, shift one step in dir and return to MOVE. If mode ≠ bounce at any tick in DWELL, leave immediately and apply that mode's step on the same tick.
- Integrity: on any tick where LEDR is not one-hot, LEDR ← 8'h80 and dir ← 0, with no other action.
- Mode and speed changes take effect at the next tick. Neither alters LEDR asynchronously.

## Timing
- tick is high for exactly one cycle every BASE_DIV >> speed cycles while run = 1.
- The first tick is high in cycle limit + 1 after the first edge that samples run = 1.
- LEDR/dir update at the edge that ends the tick-high cycle, so they are visible one cycle after tick.
- A speed change with cnt ≥ new limit produces a tick on the next edge; there is no missed or double tick beyond that.
- run falling: tick is 0 from the next cycle; no further LEDR change.
- RESET asserted mid-operation: outputs return to reset values immediately (asynchronous). Stepping resumes normally after deassertion.
- Bounce cycle length at PAUSE_TICKS = P is 14 + 2P ticks (80 → 01 → 80).

## Test plan
- Reset with run = 0, BASE_DIV = 8, held 30 cycles → LEDR = 8'h80, dir = 0, tick = 0 throughout.
- Bounce, speed 0, P = 1, run = 1 → tick every 8 cycles. LEDR sequence 80, 40, 20, 10, 08, 04, 02, 01, 01, 02, …, 80, 80, 40. dir flips at the first 01 and at the first return to 80.
- Rotate right, speed 3 (tick every cycle), starting from 8'h02 → 01, 80, 40 on consecutive cycles; dir = 0.
- Speed 0 → 3 while cnt = 5 → tick on the very next edge, then every cycle.
- run dropped at LEDR = 8'h10 → LEDR stays 8'h10. Raise run again → next value 8'h08 after a full period.
- RESET pulsed asynchronously (between edges) during DWELL at 8'h01 → LEDR = 8'h80 and dir = 0 immediately. After release, 8'h80 → 8'h40 on the first tick.

Source files
------------

// File: rtl/led_bounce_ctrl.sv
// Single-LED bounce/rotate sequencer for the 8-LED bar.
// A prescaler produces a registered step strobe, and a small FSM advances the pattern on each strobe.
module led_bounce_ctrl #(
  parameter int unsigned BASE_DIV    = 50_000_000,
  parameter int unsigned PAUSE_TICKS = 1
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       run,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  output logic [7:0] LEDR,
  output logic       dir,
  output logic       tick
);

  localparam int unsigned CNT_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int unsigned DW_W  = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS + 1) : 1;

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_ROT_R  = 2'b01;
  localparam logic [1:0] MODE_ROT_L  = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  limit;
  logic              tick_q, tick_d;
  logic [7:0]        ledr_q, ledr_d;
  logic              dir_q, dir_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [31:0]       dwell_next;
  logic              at_end;

  function automatic logic [7:0] shift_f(input logic [7:0] p, input logic d);
    return d ? {p[6:0], 1'b0} : {1'b0, p[7:1]};
  endfunction

  assign limit      = CNT_W'((BASE_DIV >> speed) - 32'd1);
  assign dwell_next = 32'(dwell_q) + 32'd1;
  assign at_end     = dir_q ? (ledr_q == 8'h80) : (ledr_q == 8'h01);

  // Prescaler: >= compare so a speed increase past the current count ticks at once
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (run) begin
      if (cnt_q >= limit) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Next-state and pattern update, acting on the registered strobe
  always_comb begin
    state_d = state_q;
    ledr_d  = ledr_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    if (!run) begin
      state_d = IDLE;
      dwell_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = MOVE;
        MOVE, DWELL: begin
          if (tick_q) begin
            if (!$onehot(ledr_q)) begin
              ledr_d = 8'h80;
              dir_d  = 1'b0;
            end else if (state_q == DWELL && mode == MODE_BOUNCE) begin
              if (dwell_next >= PAUSE_TICKS) begin
                ledr_d  = shift_f(ledr_q, dir_q);
                dwell_d = '0;
                state_d = MOVE;
              end else begin
                dwell_d = DW_W'(dwell_next);
              end
            end else begin
              state_d = MOVE;
              dwell_d = '0;
              case (mode)
                MODE_BOUNCE: begin
                  if (!at_end) begin
                    ledr_d = shift_f(ledr_q, dir_q);
                  end else if (PAUSE_TICKS == 0) begin
                    dir_d  = ~dir_q;
                    ledr_d = shift_f(ledr_q, ~dir_q);
                  end else begin
                    dir_d   = ~dir_q;
                    state_d = DWELL;
                  end
                end
                MODE_ROT_R: begin
                  ledr_d = {ledr_q[0], ledr_q[7:1]};
                  dir_d  = 1'b0;
                end
                MODE_ROT_L: begin
                  ledr_d = {ledr_q[6:0], ledr_q[7]};
                  dir_d  = 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      ledr_q  <= 8'h80;
      dir_q   <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      ledr_q  <= ledr_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
    end
  end

  assign LEDR = ledr_q;
  assign dir  = dir_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_bounce_ctrl.sv
// Bench for led_bounce_ctrl with BASE_DIV = 8 and PAUSE_TICKS = 1.
// Expected {dir, LEDR} per step is queued by the stimulus; a monitor pops one entry after every tick.
module tb_led_bounce_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [7:0] ledr;
  logic       dir;
  logic       tick;

  int total = 0;
  int bad   = 0;

  logic [8:0]  exp_q[$];
  string       dq_name[$];
  logic [15:0] dq_act[$];
  logic [15:0] dq_exp[$];

  led_bounce_ctrl #(.BASE_DIV(8), .PAUSE_TICKS(1)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .run      (run),
    .mode     (mode),
    .speed    (speed),
    .LEDR     (ledr),
    .dir      (dir),
    .tick     (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    dq_name.push_back(nm);
    dq_act.push_back(a);
    dq_exp.push_back(e);
  endtask

  // Waits for the next tick (bounded) and checks how many negedges it took.
  task automatic wait_tick(input int exp_n);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(negedge clk);
      n++;
      if (tick) got = 1'b1;
    end
    chk("tick_gap", 16'(n), 16'(exp_n));
  endtask

  // Monitor: one scoreboard pop per tick, plus draining of queued direct checks
  initial begin
    logic [8:0] e;
    logic       tick_seen;
    string      nm;
    logic [15:0] a, x;
    tick_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tick_seen = 1'b0;
      end else begin
        if (tick_seen) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL step: unexpected step, got {dir,LEDR}=%h want no step", {dir, ledr});
          end else begin
            e = exp_q.pop_front();
            if ({dir, ledr} !== e) begin
              bad++;
              $display("FAIL step: got {dir,LEDR}=%h want %h", {dir, ledr}, e);
            end
          end
        end
        tick_seen = tick;
      end
      while (dq_name.size() > 0) begin
        nm = dq_name.pop_front();
        a  = dq_act.pop_front();
        x  = dq_exp.pop_front();
        total++;
        if (a !== x) begin
          bad++;
          $display("FAIL %s: got %h want %h", nm, a, x);
        end
      end
    end
  end

  logic [8:0] bounce_seq [17] = '{9'h040, 9'h020, 9'h010, 9'h008, 9'h004, 9'h002, 9'h001,
                                  9'h101, 9'h102, 9'h104, 9'h108, 9'h110, 9'h120, 9'h140,
                                  9'h180, 9'h080, 9'h040};
  logic [1:0] fast_mode [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
  logic [8:0] fast_exp  [8] = '{9'h020, 9'h010, 9'h008, 9'h004, 9'h002, 9'h001, 9'h080, 9'h040};

  initial begin
    rst   = 1'b1;
    run   = 1'b0;
    mode  = 2'd0;
    speed = 2'd0;

    repeat (30) begin
      @(negedge clk);
      chk("reset_hold", {6'b0, dir, tick, ledr}, 16'h0080);
    end

    // Bounce at speed 0: full 80 -> 01 -> 80 cycle with one dwell tick at each end
    for (int i = 0; i < 17; i++) exp_q.push_back(bounce_seq[i]);
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 17; i++) wait_tick(8);

    // Speed 0 -> 3 with the count at 5: tick on the next edge, then every cycle
    repeat (5) @(posedge clk);
    #1 speed = 2'd3;
    for (int i = 0; i < 8; i++) begin
      wait_tick((i == 0) ? 2 : 1);
      mode = fast_mode[i];
      exp_q.push_back(fast_exp[i]);
    end
    speed = 2'd0;
    @(posedge clk);
    #1 mode = 2'd0;

    // Stop at 8'h10, then resume after a full period
    wait_tick(8);
    exp_q.push_back(9'h020);
    wait_tick(8);
    exp_q.push_back(9'h010);
    @(negedge clk);
    run = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("run_stop", {6'b0, dir, tick, ledr}, 16'h0010);
    end
    run = 1'b1;
    wait_tick(8);
    exp_q.push_back(9'h008);
    wait_tick(8);
    exp_q.push_back(9'h004);
    wait_tick(8);
    exp_q.push_back(9'h002);
    wait_tick(8);
    exp_q.push_back(9'h001);
    wait_tick(8);
    exp_q.push_back(9'h101);

    // Asynchronous reset while dwelling at 8'h01
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {6'b0, dir, tick, ledr}, 16'h0080);
    @(negedge clk);
    chk("reset_held", {6'b0, dir, tick, ledr}, 16'h0080);
    #2 rst = 1'b0;
    wait_tick(8);
    exp_q.push_back(9'h040);

    repeat (2) @(negedge clk);
    chk("sb_empty", 16'(exp_q.size()), 16'h0000);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
